// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Runs every RAM transaction requested over the MFA/MOC handshake: byte,
//   halfword, word and two-beat doubleword reads and writes. It checks
//   alignment, steers byte lanes, splits doublewords into two word beats and
//   emits a single-cycle MOC (or Abort) per accepted request.
//   Optional feature: define MEM_TIMEOUT_EN to abort a beat that sees no
//   RamReady for TIMEOUT_CYCLES beat cycles. Without it a beat waits forever.

module mem_access_sequencer #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  input  logic [31:0]       WrDataHi,
  output logic [31:0]       RdData,
  output logic [31:0]       RdDataHi,
  output logic              MOC,
  output logic              Busy,
  output logic              Abort,
  output logic              RamEn,
  output logic              RamRW,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [31:0]       RamWData,
  output logic [3:0]        RamBE,
  input  logic [31:0]       RamRData,
  input  logic              RamReady
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic              rw_q, rw_d;
  size_e             size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       wr_data_hi_q, wr_data_hi_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       rd_data_hi_q, rd_data_hi_d;

  logic              req_accept;
  logic              misaligned;
  logic              in_beat;
  logic              timeout_hit;
  logic [ADDR_W-1:0] beat_addr;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  // Address bits above the RAM window are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDR_W];

  assign req_accept = (state_q == ST_IDLE) && MFA && armed_q;
  assign in_beat    = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);

  // Alignment check on the incoming request (natural alignment per size).
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case can leave it unassigned (latch).
    misaligned = 1'b0;
    case (size_e'(Size))
      SZ_HALF:  misaligned = Addr[0];
      SZ_WORD:  misaligned = |Addr[1:0];
      SZ_DWORD: misaligned = |Addr[2:0];
      default:  misaligned = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The last allowed stalled cycle of a beat turns into an abort.
  assign timeout_hit = in_beat && !RamReady &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: restarts on entry to every beat, counts RamReady=0 cycles.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_beat && (state_d == state_q) && !RamReady) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // Timeout length only matters when the timeout feature is built in.
  logic [31:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          state_d = misaligned ? ST_ERR : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (RamReady) begin
          state_d = (size_q == SZ_DWORD) ? ST_BEAT1 : ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_BEAT1: begin
        if (RamReady) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and re-arm: one request per MFA high period.
  always_comb begin
    armed_d      = armed_q;
    rw_d         = rw_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wr_data_hi_d = wr_data_hi_q;
    if (state_q == ST_IDLE) begin
      if (req_accept) begin
        armed_d      = 1'b0;
        rw_d         = RW;
        size_d       = size_e'(Size);
        addr_d       = Addr[ADDR_W-1:0];
        wr_data_d    = WrData;
        wr_data_hi_d = WrDataHi;
      end else if (!MFA) begin
        armed_d = 1'b1;
      end
    end
  end

  // Read lane extraction: the addressed byte/half, zero-extended.
  always_comb begin
    lane_rdata = RamRData;
    case (size_q)
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0:    lane_rdata = {24'd0, RamRData[7:0]};
          2'd1:    lane_rdata = {24'd0, RamRData[15:8]};
          2'd2:    lane_rdata = {24'd0, RamRData[23:16]};
          default: lane_rdata = {24'd0, RamRData[31:24]};
        endcase
      end
      SZ_HALF: begin
        lane_rdata = addr_q[1] ? {16'd0, RamRData[31:16]} : {16'd0, RamRData[15:0]};
      end
      default: lane_rdata = RamRData;
    endcase
  end

  // Read data capture: BEAT0 fills RdData, BEAT1 fills RdDataHi.
  always_comb begin
    rd_data_d    = rd_data_q;
    rd_data_hi_d = rd_data_hi_q;
    if (rw_q && RamReady) begin
      if (state_q == ST_BEAT0) begin
        rd_data_d = lane_rdata;
      end else if (state_q == ST_BEAT1) begin
        rd_data_hi_d = RamRData;
      end
    end
  end

  // Write lane steering: byte enables and replicated write data.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wr_data_q;
    case (size_q)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wr_data_q[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wr_data_q[15:0]}};
      end
      SZ_DWORD: begin
        lane_be    = 4'b1111;
        lane_wdata = (state_q == ST_BEAT1) ? wr_data_hi_q : wr_data_q;
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wr_data_q;
      end
    endcase
  end

  // The second doubleword beat targets the next word, wrapping in the window.
  assign beat_addr = (state_q == ST_BEAT1) ? (addr_q + ADDR_W'(4)) : addr_q;

  // Outputs decoded from the current state; RAM strobes only during beats.
  always_comb begin
    Busy     = (state_q != ST_IDLE);
    MOC      = (state_q == ST_DONE);
    Abort    = (state_q == ST_ERR);
    RamEn    = in_beat;
    RamRW    = in_beat && rw_q;
    RamAddr  = in_beat ? {beat_addr[ADDR_W-1:2], 2'b00} : '0;
    RamBE    = (in_beat && !rw_q) ? lane_be : 4'b0000;
    RamWData = (in_beat && !rw_q) ? lane_wdata : 32'd0;
    RdData   = rd_data_q;
    RdDataHi = rd_data_hi_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of order.
    if (Reset) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b1;
      rw_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      wr_data_q    <= 32'd0;
      wr_data_hi_q <= 32'd0;
      rd_data_q    <= 32'd0;
      rd_data_hi_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_data_hi_q <= wr_data_hi_d;
      rd_data_q    <= rd_data_d;
      rd_data_hi_q <= rd_data_hi_d;
    end
  end

endmodule
